// File: rtl/delay_drain_fifo.sv
// delay_drain_fifo: show-ahead FIFO draining a delay line, with afull throttle and sticky overflow flag.
module delay_drain_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     afull,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, full, push, pop;
  always_comb begin
    full  = cnt_q == CW'(DEPTH);
    pop   = (cnt_q != '0) && out_ready;
    push  = in_valid && (!full || pop);
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
    // a fresh overflow outranks a coincident clear
    ovf_d = (in_valid && full && !pop) || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end
  assign usedw     = cnt_q;
  assign out_valid = cnt_q != '0;
  assign out_data  = mem_q[rd_q];
  assign afull     = cnt_q >= CW'(DEPTH - AFULL_MARGIN);
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_delay_drain_fifo.sv
// tb_delay_drain_fifo: table-driven and sequence checks of delay_drain_fifo at DEPTH=4, WIDTH=8.
module tb_delay_drain_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] in_data = '0, out_data;
  logic afull, out_valid, ovf;
  logic [2:0] usedw;
  int errors = 0, checks = 0;

  delay_drain_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .afull(afull),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .usedw(usedw), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic iv; logic [7:0] d; logic rdy; logic clr;
    logic ev; logic [7:0] ed; logic [2:0] eu; logic eaf; logic eov;
  } vec_t;
  vec_t vecs [23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid = iv; in_data = d; out_ready = rdy; ovf_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, got, cyc;
    logic rt;
    vecs = '{
      '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0, 1'b0},
      '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1, 1'b0},
      '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0},
      '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0},
      '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0},
      '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h22, 3'd4, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 3'd3, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 3'd2, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 3'd1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
      '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0, 1'b0},
      '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b1, 1'b0},
      '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b1, 1'b0},
      '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1, 1'b0},
      '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1, 1'b0},
      '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h02, 3'd4, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd3, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 3'd1, 1'b0, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}
    };
    // reset state while rst is held across edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset usedw", usedw, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset afull", afull, 0);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;
    #3;
    for (int i = 0; i < 23; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].ed);
      chk($sformatf("vec%0d usedw", i), usedw, vecs[i].eu);
      chk($sformatf("vec%0d afull", i), afull, vecs[i].eaf);
      chk($sformatf("vec%0d ovf", i), ovf, vecs[i].eov);
    end
    // empty FIFO: no bypass on the push cycle
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    chk("nobypass out_valid same cycle", out_valid, 0);
    @(posedge clk); #1;
    chk("nobypass out_valid next", out_valid, 1);
    chk("nobypass out_data next", out_data, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("nobypass drained", usedw, 0);
    // stream with afull throttling and alternating out_ready, wrapping pointers
    sent = 0; got = 0; cyc = 0; rt = 1'b1;
    while ((sent < 12 || got < 12) && cyc < 200) begin
      in_valid = (sent < 12) && !afull; in_data = 8'(sent); out_ready = rt; ovf_clr = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("stream word%0d", got), out_data, got);
        got++;
      end
      if (in_valid) sent++;
      @(posedge clk); #1;
      rt = ~rt; cyc++;
    end
    chk("stream words received", got, 12);
    chk("stream ovf", ovf, 0);
    chk("stream usedw end", usedw, 0);
    // mid-cycle asynchronous reset with ovf set and three words stored
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre-rst usedw", usedw, 3);
    chk("pre-rst ovf", ovf, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst usedw", usedw, 0);
    chk("async rst out_valid", out_valid, 0);
    chk("async rst ovf", ovf, 0);
    chk("async rst afull", afull, 0);
    @(posedge clk); #1 rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post-rst out_valid", out_valid, 1);
    chk("post-rst out_data", out_data, 8'h77);
    chk("post-rst usedw", usedw, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
